// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: frames each received byte with
// the errors reported until the frame ends, then queues it in a FWFT FIFO.
module uart_rx_fifo #(
   parameter int p_depth     = 16,
   parameter int p_addr_bits = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [7:0]             rx_data_i,
   input  logic                   rx_data_ready_i,
   input  logic                   rx_busy_i,
   input  logic                   rx_parity_err_i,
   input  logic                   rx_framing_err_i,
   input  logic                   rd_en_i,
   input  logic                   clear_overrun_i,
   output logic [7:0]             data_o,
   output logic                   parity_err_o,
   output logic                   framing_err_o,
   output logic                   valid_o,
   output logic                   full_o,
   output logic [p_addr_bits:0]   count_o,
   output logic                   overrun_o
);

   localparam logic [p_addr_bits:0]   c_depth   = (p_addr_bits + 1)'(p_depth);
   localparam logic [p_addr_bits:0]   c_cnt_one = (p_addr_bits + 1)'(1);
   localparam logic [p_addr_bits-1:0] c_ptr_one = p_addr_bits'(1);

   typedef enum logic {
      S_IDLE,
      S_WAIT_END
   } state_t;

   state_t                 state_q;
   logic                   rdy_q;
   logic                   rise;
   logic [7:0]             hold_byte_q;
   logic                   par_acc_q;
   logic                   frm_acc_q;

   logic                   push_req;
   logic [9:0]             push_word;
   logic                   do_push;
   logic                   do_pop;
   logic                   drop;

   logic [9:0]             mem [p_depth];
   logic [p_addr_bits-1:0] wr_ptr_q;
   logic [p_addr_bits-1:0] rd_ptr_q;
   logic [p_addr_bits:0]   count_q;
   logic [p_addr_bits:0]   count_nxt;
   logic                   full_q;
   logic                   overrun_q;
   logic [9:0]             head_word;

   assign rise = rx_data_ready_i & ~rdy_q;

   // A frame ends when the receiver goes idle, or when a new byte arrives
   // before busy ever dropped (back-to-back frames).
   assign push_req  = (state_q == S_WAIT_END) & (rise | ~rx_busy_i);
   assign push_word = {frm_acc_q | rx_framing_err_i,
                       par_acc_q | rx_parity_err_i,
                       hold_byte_q};

   // Frame capture: a rise in WAIT_END wins over busy low so no byte is lost;
   // the freshly latched byte is then pushed on the following idle cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         rdy_q       <= 1'b0;
         hold_byte_q <= '0;
         par_acc_q   <= 1'b0;
         frm_acc_q   <= 1'b0;
      end else begin
         rdy_q <= rx_data_ready_i;
         case (state_q)
            S_IDLE: begin
               if (rise) begin
                  hold_byte_q <= rx_data_i;
                  par_acc_q   <= 1'b0;
                  frm_acc_q   <= 1'b0;
                  state_q     <= S_WAIT_END;
               end
            end
            S_WAIT_END: begin
               if (rise) begin
                  hold_byte_q <= rx_data_i;
                  par_acc_q   <= 1'b0;
                  frm_acc_q   <= 1'b0;
               end else if (!rx_busy_i) begin
                  state_q <= S_IDLE;
               end else begin
                  par_acc_q <= par_acc_q | rx_parity_err_i;
                  frm_acc_q <= frm_acc_q | rx_framing_err_i;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Read side handshake: valid_o means the head entry on data_o/tags is
   // meaningful; rd_en_i acts as ready and an entry leaves only on a cycle
   // where both are high. rd_en_i with valid_o low is ignored.
   assign valid_o = (count_q != '0);
   assign do_pop  = rd_en_i & valid_o;
   assign do_push = push_req & (~full_q | do_pop);
   assign drop    = push_req & full_q & ~do_pop;

   always_comb begin
      count_nxt = count_q;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count_q + c_cnt_one;
         2'b01:   count_nxt = count_q - c_cnt_one;
         default: count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
         count_q <= count_nxt;
         full_q  <= (count_nxt == c_depth);
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (clear_overrun_i) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Storage is deliberately not reset; the head is masked while empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_q] <= push_word;
   end

   assign head_word     = valid_o ? mem[rd_ptr_q] : 10'd0;
   assign data_o        = head_word[7:0];
   assign parity_err_o  = head_word[8];
   assign framing_err_o = head_word[9];
   assign full_o        = full_q;
   assign count_o       = count_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table of single frames plus hand-written fill,
// overrun, simultaneous push/pop and async reset sequences.
module tb_uart_rx_fifo;

   logic       clk_i;
   logic       rst_n_i;
   logic [7:0] rx_data_i;
   logic       rx_data_ready_i;
   logic       rx_busy_i;
   logic       rx_parity_err_i;
   logic       rx_framing_err_i;
   logic       rd_en_i;
   logic       clear_overrun_i;
   logic [7:0] data_o;
   logic       parity_err_o;
   logic       framing_err_o;
   logic       valid_o;
   logic       full_o;
   logic [4:0] count_o;
   logic       overrun_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] exp_q[$];

   typedef struct {
      logic [7:0] b;
      bit         par;
      bit         frm;
      int         len;
      logic [9:0] exp_word;
   } vec_t;

   vec_t vecs[6];

   uart_rx_fifo #(.p_depth(16), .p_addr_bits(4)) dut (
      .clk_i(clk_i),
      .rst_n_i(rst_n_i),
      .rx_data_i(rx_data_i),
      .rx_data_ready_i(rx_data_ready_i),
      .rx_busy_i(rx_busy_i),
      .rx_parity_err_i(rx_parity_err_i),
      .rx_framing_err_i(rx_framing_err_i),
      .rd_en_i(rd_en_i),
      .clear_overrun_i(clear_overrun_i),
      .data_o(data_o),
      .parity_err_o(parity_err_o),
      .framing_err_o(framing_err_o),
      .valid_o(valid_o),
      .full_o(full_o),
      .count_o(count_o),
      .overrun_o(overrun_o)
   );

   // clock/reset
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Compare the head against the scoreboard, then pop it.
   task automatic pop_check(input string name);
      logic [9:0] e;
      check({name, "_valid"}, 32'(valid_o), 32'd1);
      if (exp_q.size() == 0) begin
         check({name, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({name, "_word"}, 32'({framing_err_o, parity_err_o, data_o}), 32'(e));
      end
      rd_en_i = 1'b1;
      tick();
      rd_en_i = 1'b0;
   endtask

   // end_mode: 0 = nothing, 1 = pop on the busy-fall cycle, 2 = clear_overrun then.
   task automatic send_frame(input logic [7:0] b, input bit par, input bit frm,
                             input int len, input int end_mode,
                             output logic [4:0] cnt_after, output logic valid_after);
      logic [9:0] e;
      rx_data_i       = b;
      rx_data_ready_i = 1'b1;
      rx_busy_i       = 1'b1;
      tick();
      for (int i = 1; i < len; i++) begin
         rx_parity_err_i = par && (i == len / 2);
         tick();
      end
      rx_parity_err_i  = 1'b0;
      rx_busy_i        = 1'b0;
      rx_framing_err_i = frm;
      if (end_mode == 1) begin
         rd_en_i = 1'b1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pop_at_push_word", 32'({framing_err_o, parity_err_o, data_o}), 32'(e));
         end
      end
      if (end_mode == 2) clear_overrun_i = 1'b1;
      tick();
      cnt_after        = count_o;
      valid_after      = valid_o;
      rx_framing_err_i = 1'b0;
      rx_data_ready_i  = 1'b0;
      rd_en_i          = 1'b0;
      clear_overrun_i  = 1'b0;
      tick();
   endtask

   initial begin
      logic [4:0] cnt;
      logic       vld;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 100, 10'h0A5};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 20,  10'h13C};
      vecs[2] = '{8'h3C, 1'b0, 1'b1, 20,  10'h23C};
      vecs[3] = '{8'h5A, 1'b1, 1'b1, 10,  10'h35A};
      vecs[4] = '{8'hFF, 1'b0, 1'b0, 3,   10'h0FF};
      vecs[5] = '{8'h00, 1'b0, 1'b0, 2,   10'h000};

      rst_n_i          = 1'b0;
      rx_data_i        = '0;
      rx_data_ready_i  = 1'b0;
      rx_busy_i        = 1'b0;
      rx_parity_err_i  = 1'b0;
      rx_framing_err_i = 1'b0;
      rd_en_i          = 1'b0;
      clear_overrun_i  = 1'b0;
      repeat (3) tick();
      check("rst_valid",   32'(valid_o),   32'd0);
      check("rst_count",   32'(count_o),   32'd0);
      check("rst_full",    32'(full_o),    32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      check("rst_head",    32'({framing_err_o, parity_err_o, data_o}), 32'd0);
      rst_n_i = 1'b1;
      tick();

      // single frames from the table
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].b, vecs[i].par, vecs[i].frm, vecs[i].len, 0, cnt, vld);
         exp_q.push_back(vecs[i].exp_word);
         check($sformatf("vec%0d_count_at_push", i), 32'(cnt), 32'd1);
         check($sformatf("vec%0d_valid_at_push", i), 32'(vld), 32'd1);
         pop_check($sformatf("vec%0d", i));
         check($sformatf("vec%0d_empty", i), 32'(valid_o), 32'd0);
         check($sformatf("vec%0d_count0", i), 32'(count_o), 32'd0);
      end

      // noise start bit: busy without a ready rise
      rx_busy_i = 1'b1;
      repeat (50) tick();
      rx_busy_i = 1'b0;
      repeat (3) tick();
      check("noise_count", 32'(count_o), 32'd0);

      // pop on empty FIFO in the same cycle as a push pops nothing
      send_frame(8'h81, 1'b0, 1'b0, 4, 1, cnt, vld);
      exp_q.push_back(10'h081);
      check("empty_pushpop_count", 32'(cnt), 32'd1);
      pop_check("empty_pushpop");

      // fill, overrun, drain in order
      for (int i = 0; i < 16; i++) begin
         send_frame(8'(i), 1'b0, 1'b0, 2, 0, cnt, vld);
         exp_q.push_back(10'(i));
      end
      check("fill_full",    32'(full_o),    32'd1);
      check("fill_count",   32'(count_o),   32'd16);
      check("fill_overrun", 32'(overrun_o), 32'd0);
      send_frame(8'hFF, 1'b0, 1'b0, 2, 0, cnt, vld);
      check("ovr_overrun", 32'(overrun_o), 32'd1);
      check("ovr_count",   32'(count_o),   32'd16);
      for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
      check("drain_valid",  32'(valid_o),   32'd0);
      check("drain_full",   32'(full_o),    32'd0);
      check("ovr_sticky",   32'(overrun_o), 32'd1);
      clear_overrun_i = 1'b1;
      tick();
      clear_overrun_i = 1'b0;
      check("ovr_cleared", 32'(overrun_o), 32'd0);

      // push and pop together while full
      for (int i = 0; i < 16; i++) begin
         send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 2, 0, cnt, vld);
         exp_q.push_back(10'h010 + 10'(i));
      end
      send_frame(8'hFF, 1'b0, 1'b0, 2, 1, cnt, vld);
      exp_q.push_back(10'h0FF);
      check("pp_full_count",   32'(cnt),       32'd16);
      check("pp_full_overrun", 32'(overrun_o), 32'd0);
      check("pp_full_full",    32'(full_o),    32'd1);

      // dropped push and clear in the same cycle: set wins
      send_frame(8'hEE, 1'b0, 1'b0, 2, 2, cnt, vld);
      check("setwins_overrun", 32'(overrun_o), 32'd1);
      check("setwins_count",   32'(count_o),   32'd16);
      for (int i = 0; i < 16; i++) pop_check($sformatf("pp_drain%0d", i));
      clear_overrun_i = 1'b1;
      tick();
      clear_overrun_i = 1'b0;

      // async reset with 3 entries and a pending frame
      for (int i = 0; i < 3; i++) begin
         send_frame(8'h60 + 8'(i), 1'b0, 1'b0, 2, 0, cnt, vld);
         exp_q.push_back(10'h060 + 10'(i));
      end
      rx_data_i       = 8'h77;
      rx_data_ready_i = 1'b1;
      rx_busy_i       = 1'b1;
      repeat (4) tick();
      check("pre_rst_count", 32'(count_o), 32'd3);
      #3;
      rst_n_i = 1'b0;
      #1;
      check("arst_valid", 32'(valid_o), 32'd0);
      check("arst_count", 32'(count_o), 32'd0);
      check("arst_full",  32'(full_o),  32'd0);
      check("arst_head",  32'({framing_err_o, parity_err_o, data_o}), 32'd0);
      exp_q.delete();
      rx_data_ready_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
      repeat (3) tick();
      rx_busy_i = 1'b0;
      repeat (3) tick();
      check("post_rst_count", 32'(count_o), 32'd0);
      check("post_rst_valid", 32'(valid_o), 32'd0);

      // the FIFO still works after reset
      send_frame(8'hC3, 1'b1, 1'b0, 6, 0, cnt, vld);
      exp_q.push_back(10'h1C3);
      pop_check("post_rst_frame");
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver. It captures each received byte when the receiver's data-ready flag rises, and collects any parity or framing error the receiver reports until that frame ends. At frame end it pushes a tagged entry {framing_err, parity_err, byte} into a first-word-fall-through FIFO. The host/bus side pops entries at its own pace; overflow sets a sticky overrun flag.

Parameters:
p_depth, 16, number of FIFO entries; must be a power of 2 and at least 2
p_addr_bits, 4, log2(p_depth); pointer width

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset, asynchronous, active-low
rx_data_i  input  8  byte from receiver (receiver data_o)
rx_data_ready_i  input  1  receiver data-ready level; rising edge = new byte
rx_busy_i  input  1  receiver busy; low = receiver idle, frame finished
rx_parity_err_i  input  1  receiver parity error (may pulse)
rx_framing_err_i  input  1  receiver framing error (may pulse)
rd_en_i  input  1  pop head entry; ignored when valid_o=0
clear_overrun_i  input  1  clears overrun_o
data_o  output  8  head entry byte
parity_err_o  output  1  head entry parity-error tag
framing_err_o  output  1  head entry framing-error tag
valid_o  output  1  FIFO not empty
full_o  output  1  count_o == p_depth
count_o  output  p_addr_bits+1  current occupancy, 0..p_depth
overrun_o  output  1  sticky: a completed frame was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE; pointers=0; count_o=0; valid_o=0; full_o=0; overrun_o=0; holding register and error accumulators=0; ready-edge register=0. data_o, parity_err_o and framing_err_o read 0 while empty. RAM contents are not reset. Reset mid-frame discards the pending byte.
- Edge detect: rdy_q <= rx_data_ready_i each cycle. rise = rx_data_ready_i & ~rdy_q.
- FSM, 2 states:
  - IDLE: on rise, latch rx_data_i into hold_byte, clear both error accumulators, go to WAIT_END. If rx_busy_i=0 and there is no rise (noise start bit), do nothing.
  - WAIT_END: every cycle, par_acc |= rx_parity_err_i and frm_acc |= rx_framing_err_i. When rx_busy_i=0, push {frm_acc|rx_framing_err_i, par_acc|rx_parity_err_i, hold_byte} and go to IDLE. A rise seen in WAIT_END (back-to-back frame without busy dropping) first pushes the pending entry, then latches the new byte and stays in WAIT_END.
- Push/pop:
  - Push writes mem[wr_ptr] and increments wr_ptr, which wraps modulo p_depth.
  - Pop (rd_en_i & valid_o) increments rd_ptr, which wraps.
  - A pop with valid_o=0 has no effect.
  - Push with the FIFO full and no simultaneous pop: the entry is dropped, overrun_o <= 1, and pointers and count are unchanged.
  - Push and pop in the same cycle: always legal when valid_o=1, including when full; count is unchanged and no overrun occurs.
  - When empty, a push and pop in the same cycle pops nothing.
- Latency: valid_o and the head outputs update on the clock edge after the push cycle. After a pop, the next entry appears on data_o on the following edge (FWFT; outputs driven from mem[rd_ptr]).
- count_o and full_o are registered and exact. valid_o = (count_o != 0).
- overrun_o: set on a dropped push. Cleared by clear_overrun_i. If set and clear occur in the same cycle, set wins.

Test Plan:
- Single frame 0xA5, no errors: rx_data_ready_i rises with data 0xA5, rx_busy_i falls 100 cycles later -> next cycle valid_o=1, data_o=0xA5, both tags 0, count_o=1. Pop -> valid_o=0, count_o=0.
- Error tagging: byte 0x3C, rx_parity_err_i pulses 1 cycle during WAIT_END, then busy falls -> entry 0x3C with parity_err_o=1, framing_err_o=0. Repeat with framing pulse coincident with busy fall -> framing_err_o=1.
- Noise start: rx_busy_i high for 50 cycles, no ready rise -> count_o stays 0.
- Fill and overrun: push 16 frames 0x00..0x0F -> full_o=1. 17th frame 0xFF -> dropped, overrun_o=1, count_o=16. Pop all -> order 0x00..0x0F, pointers wrap. clear_overrun_i -> overrun_o=0.
- Simultaneous push/pop while full: pop on the same cycle as the 17th push -> no overrun, count_o=16, last entry 0xFF.
- Async reset with 3 entries and a frame pending: assert rst_n_i mid-cycle -> outputs clear immediately. After release, no stale entry is pushed on the next busy fall.
